step_sequencer: RTL and testbench

Transport and step-clock stage for the drum machine. It generates the step index `n` consumed by `user_interface`, using a tempo prescaler and a play/pause/stop state machine. It also takes back the per-drum pattern bits that `user_interface` returns for that step and turns them into registered one-cycle drum trigger pulses for the sound stage.

---
 rtl/step_sequencer.sv | 107 ++++++++++
 tb/tb_step_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/step_sequencer.sv
// Drum machine transport: a tempo prescaler plus a play/pause/stop FSM
// produce the step index, a step tick, and registered drum trigger pulses.
module step_sequencer #(
    parameter int PATTERN_WIDTH = 8,
    parameter int COUNT_WIDTH   = 4,
    parameter int DRUM_COUNT    = 5,
    parameter int TEMPO_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic                   pause_i,
    input  logic                   stop_i,
    input  logic [TEMPO_WIDTH-1:0] tempo_i,
    input  logic [DRUM_COUNT-1:0]  pattern_i,
    output logic [COUNT_WIDTH-1:0] n_o,
    output logic                   step_tick_o,
    output logic [DRUM_COUNT-1:0]  trig_o,
    output logic                   running_o
);

    typedef enum logic [1:0] {
        STOPPED,
        RUNNING,
        PAUSED
    } state_e;

    localparam logic [COUNT_WIDTH-1:0] LAST_STEP =
        COUNT_WIDTH'(PATTERN_WIDTH - 1);

    state_e                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] n_q, n_d;
    logic [TEMPO_WIDTH-1:0] presc_q, presc_d;
    logic                   tick_q, tick_d;
    logic [DRUM_COUNT-1:0]  trig_q, trig_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STOPPED;
            n_q     <= '0;
            presc_q <= '0;
            tick_q  <= 1'b0;
            trig_q  <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            trig_q  <= trig_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        // capture is keyed off the registered tick, so a trigger already
        // sampled still fires even if the transport stops this edge
        trig_d  = tick_q ? pattern_i : '0;
        unique case (state_q)
            STOPPED: begin
                n_d     = '0;
                presc_d = '0;
                if (start_i && !pause_i && !stop_i) begin
                    state_d = RUNNING;
                    tick_d  = 1'b1;
                end
            end
            RUNNING: begin
                if (stop_i) begin
                    state_d = STOPPED;
                    n_d     = '0;
                    presc_d = '0;
                end else if (pause_i) begin
                    state_d = PAUSED;
                end else if (presc_q >= tempo_i) begin
                    presc_d = '0;
                    n_d     = (n_q == LAST_STEP) ? '0 : n_q + 1'b1;
                    tick_d  = 1'b1;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            PAUSED: begin
                if (stop_i) begin
                    state_d = STOPPED;
                    n_d     = '0;
                    presc_d = '0;
                end else if (start_i && !pause_i) begin
                    state_d = RUNNING;
                end
            end
            default: begin
                state_d = STOPPED;
                n_d     = '0;
                presc_d = '0;
            end
        endcase
    end

    assign n_o         = n_q;
    assign step_tick_o = tick_q;
    assign trig_o      = trig_q;
    assign running_o   = (state_q == RUNNING);

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: directed transport scenarios plus a random
// command stream, checked cycle by cycle through an expectation queue.
module tb_step_sequencer;

    localparam int PW = 8;
    localparam int CW = 4;
    localparam int DC = 5;
    localparam int TW = 16;

    localparam int ST = 0;
    localparam int RN = 1;
    localparam int PS = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_i, pause_i, stop_i;
    logic [TW-1:0] tempo_i;
    logic [DC-1:0] pattern_i;
    logic [CW-1:0] n_o;
    logic          step_tick_o;
    logic [DC-1:0] trig_o;
    logic          running_o;

    typedef struct packed {
        logic          run;
        logic          tick;
        logic [CW-1:0] n;
        logic [DC-1:0] trig;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    int n_tests = 0;
    int n_fail  = 0;

    int            m_st, m_age, m_steps;
    logic          m_tick;
    logic [DC-1:0] m_trig;

    step_sequencer #(
        .PATTERN_WIDTH(PW),
        .COUNT_WIDTH  (CW),
        .DRUM_COUNT   (DC),
        .TEMPO_WIDTH  (TW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .pause_i    (pause_i),
        .stop_i     (stop_i),
        .tempo_i    (tempo_i),
        .pattern_i  (pattern_i),
        .n_o        (n_o),
        .step_tick_o(step_tick_o),
        .trig_o     (trig_o),
        .running_o  (running_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: steps counted as an unbounded integer, age of the
    // current step in cycles; n is the step count modulo the loop length.
    task automatic model_step();
        logic [DC-1:0] nt;
        nt = m_tick ? pattern_i : '0;
        if (!rst_n) begin
            m_st = ST; m_age = 0; m_steps = 0;
            m_tick = 1'b0; m_trig = '0;
        end else begin
            m_trig = nt;
            m_tick = 1'b0;
            if (stop_i) begin
                m_st = ST; m_age = 0; m_steps = 0;
            end else if (pause_i) begin
                if (m_st == RN) m_st = PS;
            end else if (start_i && m_st == ST) begin
                m_st = RN; m_tick = 1'b1;
            end else if (start_i && m_st == PS) begin
                m_st = RN;
            end else if (m_st == RN) begin
                if (m_age >= int'(tempo_i)) begin
                    m_age = 0; m_steps++; m_tick = 1'b1;
                end else begin
                    m_age++;
                end
            end
        end
    endtask

    task automatic cyc(input bit s, input bit p, input bit sp);
        exp_t x;
        start_i = s;
        pause_i = p;
        stop_i  = sp;
        model_step();
        x.run  = (m_st == RN);
        x.tick = m_tick;
        x.n    = CW'(m_steps % PW);
        x.trig = m_trig;
        sb.push_back(x);
        @(negedge clk);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("sb_n", n_o, e.n);
            check("sb_tick", step_tick_o, e.tick);
            check("sb_trig", trig_o, e.trig);
            check("sb_run", running_o, e.run);
        end
    end

    initial begin
        logic [CW-1:0] pn;
        rst_n = 1'b0;
        start_i = 1'b0; pause_i = 1'b0; stop_i = 1'b0;
        tempo_i = TW'(3);
        pattern_i = 5'b10110;
        m_st = ST; m_age = 0; m_steps = 0; m_tick = 1'b0; m_trig = '0;
        @(negedge clk);
        idle(2);
        check("rst_n_o", n_o, 0);
        check("rst_tick", step_tick_o, 0);
        check("rst_run", running_o, 0);
        rst_n = 1'b1;
        idle(2);

        // start, step cadence, wrap, trigger
        cyc(1'b1, 1'b0, 1'b0);
        check("start_tick", step_tick_o, 1);
        check("start_n", n_o, 0);
        idle(3);
        check("mid_tick", step_tick_o, 0);
        idle(1);
        check("t4_tick", step_tick_o, 1);
        check("t4_n", n_o, 1);
        idle(28);
        check("wrap_tick", step_tick_o, 1);
        check("wrap_n", n_o, 0);
        idle(1);
        check("trig_val", trig_o, 5'b10110);
        idle(1);
        check("trig_clr", trig_o, 0);
        idle(18);
        check("pre_rst_n", n_o, 5);

        // asynchronous reset mid-run
        rst_n = 1'b0;
        #1;
        check("arst_n", n_o, 0);
        check("arst_trig", trig_o, 0);
        check("arst_run", running_o, 0);
        check("arst_tick", step_tick_o, 0);
        idle(2);
        rst_n = 1'b1;
        idle(2);

        // pause with prescaler 2 on step 3, then resume
        cyc(1'b1, 1'b0, 1'b0);
        idle(14);
        cyc(1'b0, 1'b1, 1'b0);
        check("pause_n", n_o, 3);
        check("pause_run", running_o, 0);
        idle(20);
        check("paused_n", n_o, 3);
        cyc(1'b1, 1'b0, 1'b0);
        check("resume_tick", step_tick_o, 0);
        check("resume_run", running_o, 1);
        idle(1);
        check("resume1_tick", step_tick_o, 0);
        idle(1);
        check("resume2_tick", step_tick_o, 1);
        check("resume2_n", n_o, 4);

        // all commands at once while running
        cyc(1'b1, 1'b1, 1'b1);
        check("all_run", running_o, 0);
        check("all_n", n_o, 0);
        idle(3);
        cyc(1'b1, 1'b0, 1'b0);
        check("restart_tick", step_tick_o, 1);
        check("restart_n", n_o, 0);

        // tempo 0: a step every cycle, trig tracks pattern
        tempo_i = '0;
        for (int i = 0; i < 10; i++) begin
            pn = n_o;
            pattern_i = DC'($urandom);
            cyc(1'b0, 1'b0, 1'b0);
            check("t0_tick", step_tick_o, 1);
            check("t0_n", n_o, CW'((int'(pn) + 1) % PW));
        end

        // tempo reduced mid-step takes effect at the next edge
        cyc(1'b0, 1'b0, 1'b1);
        tempo_i = TW'(9);
        cyc(1'b1, 1'b0, 1'b0);
        idle(6);
        tempo_i = TW'(2);
        idle(1);
        check("tdrop_tick", step_tick_o, 1);
        check("tdrop_n", n_o, 1);
        idle(2);
        check("tdrop_gap", step_tick_o, 0);
        idle(1);
        check("tdrop_next", step_tick_o, 1);
        check("tdrop_next_n", n_o, 2);

        // random single-command stream
        for (int i = 0; i < 400; i++) begin
            int r;
            if (i % 50 == 0) tempo_i = TW'($urandom_range(0, 5));
            pattern_i = DC'($urandom);
            r = $urandom_range(0, 19);
            cyc(r == 0 || r == 3, r == 1, r == 2);
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
